multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have one parameter: WIDTH, default 32, operand and result width; all values below assume WIDTH=32.
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port data_operandA, input, WIDTH, signed multiplicand/dividend.
REQ-005 SHALL have port data_operandB, input, WIDTH, signed multiplier/divisor.
REQ-006 SHALL have port ctrl_MULT, input, 1, start-multiply pulse from the execute stage.
REQ-007 SHALL have port ctrl_DIV, input, 1, start-divide pulse from the execute stage.
REQ-008 SHALL have port ctrl_flush, input, 1, abort request from the hazard/branch logic.
REQ-009 SHALL have port data_result, output, WIDTH, signed result to the X/M latch.
REQ-010 SHALL have port data_exception, output, 1, overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-011 SHALL have port data_resultRDY, output, 1, one-cycle result-valid strobe.
REQ-012 SHALL have port busy, output, 1, stall request to the hazard unit.

Function
REQ-013 SHALL implement FSM states IDLE, MULT, DIV, DONE plus a 5-bit iteration counter.
REQ-014 SHALL accept a start at any edge where ctrl_MULT or ctrl_DIV is 1, in any state, latching both operands and clearing the counter.
REQ-015 SHALL treat ctrl_MULT and ctrl_DIV both high as MULT.
REQ-016 SHALL abort any in-flight operation when a new start is accepted; the aborted operation produces no strobe.
REQ-017 SHALL perform one iteration per cycle in MULT/DIV: 32 iterations, go to DONE on the edge where the counter equals 31.
REQ-018 SHALL raise data_resultRDY exactly in the cycle after the 32nd iteration, i.e. 32 cycles after the start edge, for one cycle; DONE then returns to IDLE.
REQ-019 SHALL drive busy=1 in MULT and DIV only; busy=0 in IDLE and DONE.
REQ-020 SHALL produce mult as the low WIDTH bits of the signed 2*WIDTH product; exception=1 when the product does not fit in signed WIDTH.
REQ-021 SHALL produce div as the signed quotient truncated toward zero; the remainder is discarded.
REQ-022 SHALL set the divide-by-zero result to 0 with exception=1.
REQ-023 SHALL set 0x80000000 / -1 to result 0x80000000 with exception=1.
REQ-024 SHALL hold data_result and data_exception stable from the RDY cycle until the next accepted start.
REQ-025 SHALL, on ctrl_flush=1 without a start, go to IDLE with no strobe; a start in the same cycle wins over flush.

Reset
REQ-026 SHALL, on reset=1 at an edge, force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0, regardless of any start or flush input.
REQ-027 SHALL give reset priority over start and flush; an in-flight operation is discarded with no strobe.

Structure
REQ-028 SHALL place the state enum, the ITERATIONS=32 constant and the counter width in shared package multdiv_pkg.
REQ-029 SHALL implement operand absolute-value and result negation in combinational sub-module multdiv_signfix, instantiated once for inputs and once for the result.
REQ-030 SHALL use an iterative shift-add multiplier and a restoring unsigned divider on magnitudes; no * or / operators.

Verification
REQ-031 SHALL cover: MULT 7 x -6 -> RDY 32 cycles after start, result 0xFFFFFFD6, exception 0, busy high 32 cycles.
REQ-032 SHALL cover: MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-033 SHALL cover: DIV -43 / 5 -> result 0xFFFFFFF8 (-8), exception 0; DIV 5 / 0 -> result 0, exception 1.
REQ-034 SHALL cover: MULT 3 x 4 started, DIV 20 / 4 started 10 cycles later -> single RDY 32 cycles after the second start, result 5.
REQ-035 SHALL cover: reset asserted at cycle 15 of a DIV -> all outputs 0 next cycle, no RDY ever for that operation; flush at cycle 15 -> busy 0 next cycle, no RDY.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM state type, iteration count and counter width for multdiv_unit
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  localparam int ITERATIONS = 32;
  localparam int CNT_W = $clog2(ITERATIONS);
endpackage

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: operand/control bus from execute (master) to multdiv_unit (slave) carrying result, exception, strobe and busy back
interface multdiv_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic ctrl_MULT;
  logic ctrl_DIV;
  logic ctrl_flush;
  logic [WIDTH-1:0] data_result;
  logic data_exception;
  logic data_resultRDY;
  logic busy;
  modport master(
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_flush,
    input data_result, data_exception, data_resultRDY, busy
  );
  modport slave(
    input data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_flush,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_signfix.sv
// multdiv_signfix: N lanes of conditional two's-complement negation (val in, neg per lane, res out); abs() when neg is the sign bit
module multdiv_signfix #(
  parameter int W = 32,
  parameter int N = 1
) (
  input  logic [N-1:0][W-1:0] val,
  input  logic [N-1:0]        neg,
  output logic [N-1:0][W-1:0] res
);
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign res[g] = neg[g] ? W'(-val[g]) : val[g];
  end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-cycle multiply/divide; clock/reset plus slave bus (operands, MULT/DIV/flush in; result, exception, RDY strobe, busy out)
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clock,
  input logic reset,
  multdiv_unit_if.slave bus
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a;
  logic [2*WIDTH-1:0] p, p_nxt, mag_out, fixed;
  logic [1:0][WIDTH-1:0] mags;
  logic [WIDTH:0] sum, rr, diff;
  logic neg, bz, start, is_mult, last, exc_nxt;
  logic [WIDTH-1:0] res_nxt;
  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign is_mult = bus.ctrl_MULT;
  assign last = cnt == CNT_W'(ITERATIONS - 1);
  multdiv_signfix #(.W(WIDTH), .N(2)) u_in (
    .val({bus.data_operandA, bus.data_operandB}),
    .neg({bus.data_operandA[WIDTH-1], bus.data_operandB[WIDTH-1]}),
    .res(mags)
  );
  multdiv_signfix #(.W(2*WIDTH), .N(1)) u_out (
    .val(mag_out),
    .neg(neg),
    .res(fixed)
  );
  // p holds {accumulator, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
    rr = p[2*WIDTH-1:WIDTH-1];
    diff = rr - {1'b0, a};
    p_nxt = state == MULT ? {sum, p[WIDTH-1:1]}
                          : {diff[WIDTH] ? rr[WIDTH-1:0] : diff[WIDTH-1:0], p[WIDTH-2:0], ~diff[WIDTH]};
    mag_out = state == MULT ? p_nxt : {{WIDTH{1'b0}}, p_nxt[WIDTH-1:0]};
    // the full-width signed value must sign-extend from bit WIDTH-1; this also flags MIN / -1
    exc_nxt = bz | (fixed[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){fixed[WIDTH-1]}});
    res_nxt = bz ? '0 : fixed[WIDTH-1:0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.data_result <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy <= 1'b0;
    end else if (start) begin
      state <= is_mult ? MULT : DIV;
      cnt <= '0;
      a <= is_mult ? mags[1] : mags[0];
      p <= {{WIDTH{1'b0}}, is_mult ? mags[0] : mags[1]};
      neg <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      bz <= ~is_mult & ~|bus.data_operandB;
      bus.data_resultRDY <= 1'b0;
      bus.busy <= 1'b1;
    end else if (bus.ctrl_flush) begin
      state <= IDLE;
      bus.data_resultRDY <= 1'b0;
      bus.busy <= 1'b0;
    end else if (state == MULT || state == DIV) begin
      p <= p_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        bus.data_result <= res_nxt;
        bus.data_exception <= exc_nxt;
        bus.data_resultRDY <= 1'b1;
        bus.busy <= 1'b0;
      end
    end else begin
      state <= IDLE;
      bus.data_resultRDY <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: randomized scoreboard bench for multdiv_unit against an arithmetic reference model
module tb_multdiv_unit;
  localparam int W = 32;
  typedef struct {
    logic [31:0] res;
    logic exc;
    int edge_n;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int edges = 0;
  int checks = 0;
  int errors = 0;
  multdiv_unit_if #(.WIDTH(W)) bus ();
  multdiv_unit #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) edges <= edges + 1;
  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, want, edges);
    end
  endfunction
  function automatic void model(input logic mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint prod;
    if (mult) begin
      prod = longint'($signed(a)) * longint'($signed(b));
      r = prod[31:0];
      e = prod != longint'($signed(r));
    end else if (b == 0) begin
      r = 0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      r = a;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction
  function automatic void prune(input int s);
    while (q.size() > 0 && q[$].edge_n >= s) void'(q.pop_back());
  endfunction
  always @(negedge clock) begin
    if (bus.data_resultRDY) begin
      if (q.size() > 0 && q[0].edge_n == edges) begin
        check("result", bus.data_result, q[0].res);
        check("exception", {31'b0, bus.data_exception}, {31'b0, q[0].exc});
        void'(q.pop_front());
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: strobe at edge %0d, expected none", edges);
      end
    end else if (q.size() > 0 && q[0].edge_n <= edges) begin
      checks++;
      errors++;
      $display("FAIL missing_rdy: no strobe at edge %0d, expected result %h", edges, q[0].res);
      void'(q.pop_front());
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic go(input logic mult, input logic both, input logic fl, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic e;
    @(negedge clock);
    prune(edges + 1);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT = mult;
    bus.ctrl_DIV = ~mult | both;
    bus.ctrl_flush = fl;
    model(mult, a, b, r, e);
    q.push_back('{r, e, edges + 1 + 32});
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.ctrl_flush = 1'b0;
  endtask
  task automatic do_flush();
    @(negedge clock);
    prune(edges + 1);
    bus.ctrl_flush = 1'b1;
    @(negedge clock);
    bus.ctrl_flush = 1'b0;
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] sp[5] = '{32'h0, 32'h1, 32'hffff_ffff, 32'h8000_0000, 32'h7fff_ffff};
    int k = $urandom_range(0, 3);
    return k == 0 ? $urandom() : k == 1 ? 32'($urandom_range(0, 200)) - 32'd100
         : k == 2 ? 32'($signed($urandom()) >>> $urandom_range(8, 28)) : sp[$urandom_range(0, 4)];
  endfunction
  initial begin
    int bc;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.ctrl_flush = 1'b1;
    idle(2);
    check("reset_result", bus.data_result, 32'h0);
    check("reset_exception", {31'b0, bus.data_exception}, 32'h0);
    check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    reset = 1'b0;
    bus.ctrl_flush = 1'b0;
    go(1'b1, 1'b0, 1'b0, 32'd7, -32'sd6);
    bc = 0;
    repeat (40) begin
      if (bus.busy) bc++;
      @(negedge clock);
    end
    check("busy_cycles", bc, 32'd32);
    check("hold_result", bus.data_result, 32'hffff_ffd6);
    go(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
    idle(34);
    go(1'b0, 1'b0, 1'b0, -32'sd43, 32'd5);
    idle(34);
    go(1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
    idle(34);
    go(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hffff_ffff);
    idle(34);
    go(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'hffff_ffff);
    idle(34);
    go(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
    idle(8);
    go(1'b0, 1'b0, 1'b0, 32'd20, 32'd4);
    idle(34);
    check("hold_after_abort", bus.data_result, 32'd5);
    go(1'b0, 1'b0, 1'b0, 32'd1000, 32'd7);
    idle(14);
    @(negedge clock);
    prune(edges + 1);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_result", bus.data_result, 32'h0);
    check("midreset_exception", {31'b0, bus.data_exception}, 32'h0);
    check("midreset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    check("midreset_busy", {31'b0, bus.busy}, 32'h0);
    reset = 1'b0;
    idle(40);
    go(1'b0, 1'b0, 1'b0, -32'sd1000, 32'd7);
    idle(14);
    check("busy_before_flush", {31'b0, bus.busy}, 32'h1);
    do_flush();
    check("flush_busy", {31'b0, bus.busy}, 32'h0);
    idle(40);
    repeat (60) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      else go(1'($urandom()), 1'($urandom()), $urandom_range(0, 5) == 0, pick(), pick());
      idle($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(32, 36));
    end
    idle(40);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
